// File: rtl/edf_out_arbiter_if.sv
// Bundle between the priority FIFO bank, the EDF output arbiter and the
// egress link. master = arbiter side, slave = FIFO bank / egress side.
interface edf_out_arbiter_if #(
    parameter int N  = 4,
    parameter int DW = 16,
    parameter int PW = 2
);
    logic [N-1:0]    q_empty;
    logic [N-1:0]    q_re;
    logic [N*DW-1:0] q_dout;
    logic [N-1:0]    q_valid;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [PW-1:0]   out_port;

    modport master (
        input  q_empty, q_dout, q_valid, out_ready,
        output q_re, out_valid, out_data, out_port
    );

    modport slave (
        output q_empty, q_dout, q_valid, out_ready,
        input  q_re, out_valid, out_data, out_port
    );
endinterface

// File: rtl/edf_out_arbiter.sv
// EDF output-port scheduler: prefetches each FIFO head into a per-lane
// staging register and forwards the staged entry with the smallest deadline
// key. Optional macro EDF_RR_TIE_EN: ties on the minimum key are broken
// round-robin from rr_ptr; otherwise the lowest lane index wins.

// Per-lane prefetch engine: one outstanding read, one staged entry.
module edf_out_lane #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          empty,
    input  logic          valid,
    input  logic [DW-1:0] dout,
    input  logic          grant,
    output logic          re,
    output logic          full,
    output logic [DW-1:0] stage
);
    typedef enum logic [1:0] {L_IDLE, L_WAIT, L_FULL} lane_state_t;

    lane_state_t state, state_nxt;

    // lane state register
    always_ff @(posedge clk) begin
        if (rst) state <= L_IDLE;
        else     state <= state_nxt;
    end

    // capture returned read data only while a read is outstanding
    always_ff @(posedge clk) begin
        if (rst)                          stage <= '0;
        else if (state == L_WAIT && valid) stage <= dout;
    end

    // next state and read strobe
    always_comb begin
        state_nxt = state;
        re        = 1'b0;
        case (state)
            L_IDLE: if (!empty) begin
                re        = 1'b1;
                state_nxt = L_WAIT;
            end
            L_WAIT: if (valid) state_nxt = L_FULL;
            L_FULL: if (grant) state_nxt = L_IDLE;
            default: state_nxt = L_IDLE;
        endcase
    end

    assign full = (state == L_FULL);
endmodule

module edf_out_arbiter #(
    parameter int N  = 4,
    parameter int DW = 16,
    parameter int KW = 8,
    parameter int PW = 2
) (
    input logic             clk,
    input logic             rst,
    edf_out_arbiter_if.master bus
);
    localparam int IW = $clog2(N);

    logic [N-1:0]          full;
    logic [N-1:0]          grant;
    logic [N-1:0][DW-1:0]  stage;
    logic [IW-1:0]         rr_ptr;
    logic [IW-1:0]         win;
    logic [IW-1:0]         rr_nxt;
    logic [KW-1:0]         best_key;
    logic                  found;
    logic                  load;
    int                    idx;

    for (genvar i = 0; i < N; i++) begin : g_lane
        edf_out_lane #(.DW(DW)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .empty (bus.q_empty[i]),
            .valid (bus.q_valid[i]),
            .dout  (bus.q_dout[i*DW +: DW]),
            .grant (grant[i]),
            .re    (bus.q_re[i]),
            .full  (full[i]),
            .stage (stage[i])
        );
    end

    // earliest-deadline pick among FULL lanes; strict compare keeps the
    // first lane of the scan on ties, so the scan start sets tie priority
    always_comb begin
        win      = '0;
        best_key = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
`ifdef EDF_RR_TIE_EN
            idx = (int'(rr_ptr) + k) % N;
`else
            idx = k;
`endif
            if (full[idx] && (!found || stage[idx][DW-1 -: KW] < best_key)) begin
                found    = 1'b1;
                best_key = stage[idx][DW-1 -: KW];
                win      = IW'(idx);
            end
        end
    end

    // output register free (empty or being consumed) and something staged
    assign load   = (!bus.out_valid || bus.out_ready) && (|full);
    assign grant  = load ? ({{(N-1){1'b0}}, 1'b1} << win) : '0;
    assign rr_nxt = (win == IW'(N-1)) ? '0 : win + IW'(1);

    // output register: load the winner, drop valid once consumed and idle
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_port  <= '0;
        end else if (load) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= stage[win];
            bus.out_port  <= PW'(win);
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    // tie-break pointer advances past every winner
    always_ff @(posedge clk) begin
        if (rst) rr_ptr <= '0;
        else     rr_ptr <= load ? rr_nxt : rr_ptr;
    end
endmodule

// File: tb/tb_edf_out_arbiter.sv
// Self-checking bench for edf_out_arbiter: FIFO models per lane, a
// scoreboard of entries handed to the arbiter, and an EDF reference pick.
module tb_edf_out_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int PW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    edf_out_arbiter_if #(.N(N), .DW(DW), .PW(PW)) bus();
    edf_out_arbiter #(.N(N), .DW(DW), .KW(8), .PW(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // reference state
    logic [15:0] fifo [N][$];
    bit          inf_v [N];
    logic [15:0] inf_d [N];
    int          lat [N];
    bit          dlv [N];
    bit          pend_v [N];
    logic [15:0] pend_d [N];
    bit          hold [N];
    bit          force_qv [N];
    bit          rnd_lat, rnd_rdy, spur;
    logic        rdy;
    bit          prev_ov, prev_or;
    logic [15:0] last_d;
    logic [PW-1:0] last_p;
    int          rr_m, cyc, nout, re_cnt;
    int          re_cyc [N];
    int          plog [$];
    int          pcyc [$];

    // minimum key among handed-over entries, then the tie rule
    function automatic int exp_winner();
        int mk = 256;
        int w  = -1;
        for (int i = 0; i < N; i++)
            if (pend_v[i] && int'(pend_d[i][15:8]) < mk) mk = int'(pend_d[i][15:8]);
        for (int k = 0; k < N; k++) begin
`ifdef EDF_RR_TIE_EN
            int i = (rr_m + k) % N;
`else
            int i = k;
`endif
            if (w < 0 && pend_v[i] && int'(pend_d[i][15:8]) == mk) w = i;
        end
        return w;
    endfunction

    // one clock cycle, entered and left at a negedge
    task automatic step();
        bit any;
        int w;
        any = 0;
        for (int i = 0; i < N; i++) any |= pend_v[i];
        if (!prev_ov || prev_or) begin
            chk("out_valid", bus.out_valid, any);
            if (any && bus.out_valid) begin
                w = exp_winner();
                chk("out_port", bus.out_port, w);
                chk("out_data", bus.out_data, pend_d[w]);
                pend_v[w] = 0;
                rr_m = (w + 1) % N;
                plog.push_back(w);
                pcyc.push_back(cyc);
                nout++;
            end
        end else begin
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_data", bus.out_data, last_d);
            chk("stall_port", bus.out_port, last_p);
        end
        last_d  = bus.out_data;
        last_p  = bus.out_port;
        prev_ov = bus.out_valid;
        for (int i = 0; i < N; i++)
            if (dlv[i]) begin
                pend_v[i] = 1; pend_d[i] = inf_d[i]; inf_v[i] = 0; dlv[i] = 0;
            end
        for (int i = 0; i < N; i++) begin
            logic [15:0] d;
            logic qv;
            d  = 16'($urandom);
            qv = 1'b0;
            if (inf_v[i]) begin
                if (!hold[i]) begin
                    if (lat[i] == 0) begin qv = 1'b1; d = inf_d[i]; dlv[i] = 1; end
                    else lat[i]--;
                end
            end else if (force_qv[i] || (spur && $urandom_range(7) == 0)) begin
                qv = 1'b1;
            end
            bus.q_valid[i]         = qv;
            bus.q_dout[i*DW +: DW] = d;
            bus.q_empty[i]         = (fifo[i].size() == 0);
        end
        bus.out_ready = rnd_rdy ? 1'($urandom_range(1)) : rdy;
        prev_or = bus.out_ready;
        #1;
        for (int i = 0; i < N; i++)
            if (bus.q_re[i]) begin
                re_cnt++;
                re_cyc[i] = cyc;
                chk("re_legal", (fifo[i].size() > 0 && !inf_v[i] && !pend_v[i]), 1);
                if (fifo[i].size() > 0) begin
                    inf_v[i] = 1;
                    inf_d[i] = fifo[i].pop_front();
                    lat[i]   = rnd_lat ? int'($urandom_range(2)) : 0;
                end
            end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // reset pulse; anything in flight is lost, FIFO contents remain
    task automatic do_reset();
        rst = 1'b1;
        bus.q_valid = '0; bus.q_empty = '1; bus.q_dout = '0; bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            inf_v[i] = 0; pend_v[i] = 0; dlv[i] = 0; hold[i] = 0; force_qv[i] = 0;
        end
        prev_ov = 0; prev_or = 0; rr_m = 0;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_port", bus.out_port, 0);
        chk("rst_qre", bus.q_re, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mark, rc, c0, t;
        int exp_edf [4] = '{1, 3, 0, 2};
        int exp_bp  [4] = '{0, 1, 3, 2};
`ifdef EDF_RR_TIE_EN
        int exp_tie [5] = '{0, 1, 2, 3, 0};
`else
        int exp_tie [5] = '{0, 1, 2, 0, 1};
`endif
        rnd_lat = 0; rnd_rdy = 0; spur = 0; rdy = 1'b1;
        do_reset();

        // single lane latency
        rc = re_cnt; mark = nout; c0 = cyc;
        fifo[2].push_back(16'h3A11);
        run(6);
        chk("single_re_cnt", re_cnt - rc, 1);
        chk("single_out_cnt", nout - mark, 1);
        chk("single_port", plog[$], 2);
        chk("single_data", last_d, 16'h3A11);
        chk("single_re_cyc", re_cyc[2], c0);
        chk("single_lat", pcyc[$] - re_cyc[2], 3);

        // EDF order, back to back
        do_reset();
        mark = plog.size();
        fifo[0].push_back(16'h5000); fifo[1].push_back(16'h1001);
        fifo[2].push_back(16'hC802); fifo[3].push_back(16'h2003);
        run(8);
        chk("edf_count", plog.size() - mark, 4);
        for (int k = 0; k < 4; k++) begin
            chk("edf_order", plog[mark+k], exp_edf[k]);
            chk("edf_b2b", pcyc[mark+k] - pcyc[mark], k);
        end

        // equal keys
        do_reset();
        mark = plog.size();
        for (int i = 0; i < N; i++) begin
            fifo[i].push_back({8'h40, 8'(i)});
            fifo[i].push_back({8'h40, 8'(i + 16)});
        end
        run(14);
        chk("tie_count", plog.size() - mark, 8);
        for (int k = 0; k < 5; k++) chk("tie_order", plog[mark+k], exp_tie[k]);

        // backpressure
        do_reset();
        rdy = 1'b0;
        fifo[0].push_back(16'h3000);
        run(4);
        chk("bp_first", bus.out_data, 16'h3000);
        fifo[0].push_back(16'h0504); fifo[1].push_back(16'h1001);
        fifo[2].push_back(16'h8002); fifo[3].push_back(16'h2003);
        mark = plog.size(); rc = re_cnt;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("bp_hold", bus.out_data, 16'h3000);
            if (k == 9) c0 = re_cnt;
        end
        chk("bp_re_total", re_cnt - rc, 4);
        chk("bp_re_quiet", re_cnt - c0, 0);
        rdy = 1'b1;
        run(6);
        chk("bp_count", plog.size() - mark, 4);
        for (int k = 0; k < 4; k++) begin
            chk("bp_order", plog[mark+k], exp_bp[k]);
            chk("bp_b2b", pcyc[mark+k] - pcyc[mark], k);
        end

        // reset mid-operation
        do_reset();
        rdy = 1'b0;
        fifo[2].push_back(16'h7722);
        run(4);
        chk("mid_ov_before", bus.out_valid, 1);
        hold[0] = 1; hold[1] = 1; rc = re_cnt;
        fifo[0].push_back(16'h1111); fifo[1].push_back(16'h2222);
        run(2);
        chk("mid_reads", re_cnt - rc, 2);
        do_reset();
        mark = nout;
        force_qv[0] = 1; run(3); force_qv[0] = 0; run(3);
        chk("mid_stay_idle", nout - mark, 0);
        rdy = 1'b1;
        fifo[0].push_back(16'h0909);
        run(5);
        chk("mid_refill_cnt", nout - mark, 1);
        chk("mid_refill", last_d, 16'h0909);

        // random soak
        do_reset();
        rnd_lat = 1; rnd_rdy = 1; spur = 1;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 31; j++)
                fifo[i].push_back({8'($urandom_range(4, 200)), 8'($urandom_range(0, 100))});
        mark = nout; t = 0;
        while (nout - mark < 31 * N && t < 5000) begin
            step();
            t++;
        end
        spur = 0; rnd_rdy = 0; rdy = 1'b1;
        run(4);
        chk("soak_timeout", t < 5000, 1);
        chk("soak_count", nout - mark, 31 * N);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
